// File: rtl/spu_inst_decode.sv
// SPU even-pipe instruction decoder: classifies RR/RI10/RI16/RI18 words behind a registered 1-entry skid output.
// Optional SPU_DECODE_STATS_EN adds saturating decoded/illegal transfer counters.
module spu_inst_decode #(
  parameter int INST_W = 32,
  parameter int REG_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [10:0]       out_op,
  output logic [1:0]        out_fmt,
  output logic [REG_W-1:0]  out_rt,
  output logic [REG_W-1:0]  out_ra,
  output logic [REG_W-1:0]  out_rb,
  output logic [31:0]       out_imm,
`ifdef SPU_DECODE_STATS_EN
  output logic [31:0]       stat_decoded,
  output logic [31:0]       stat_illegal,
`endif
  output logic              out_illegal
);

  typedef struct packed {
    logic [10:0]      op;
    logic [1:0]       fmt;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [31:0]      imm;
    logic             illegal;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

  occ_t    state;
  bundle_t dec, out_q, skid_q;
  logic    is_ri18, is_ri16, is_ri10, is_rr;
  logic    accept, drain;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  always_comb begin
    is_ri18 = (in_inst[31:25] == 7'h21);
    is_ri16 = (in_inst[31:23] == 9'h081) || (in_inst[31:23] == 9'h083);
    case (in_inst[31:24])
      8'h1C, 8'h1D, 8'h0C, 8'h0D, 8'h14, 8'h15, 8'h16, 8'h04, 8'h05, 8'h06,
      8'h44, 8'h45, 8'h46, 8'h7C, 8'h7D, 8'h7E, 8'h4C, 8'h4D, 8'h4E: is_ri10 = 1'b1;
      default: is_ri10 = 1'b0;
    endcase
    case (in_inst[31:21])
      11'h0C8, 11'h0C0, 11'h048, 11'h040, 11'h340, 11'h341, 11'h0C2,
      11'h042, 11'h2A5, 11'h0C1, 11'h041, 11'h241, 11'h0C9, 11'h049,
      11'h249, 11'h3C0, 11'h3D0, 11'h3C8, 11'h240, 11'h248, 11'h250: is_rr = 1'b1;
      default: is_rr = 1'b0;
    endcase

    dec    = '0;
    dec.rt = REG_W'(in_inst[6:0]);
    if (is_ri18) begin
      dec.op  = {4'b0, in_inst[31:25]};
      dec.fmt = 2'd3;
      dec.imm = {14'b0, in_inst[24:7]};
    end else if (is_ri16) begin
      dec.op  = {2'b0, in_inst[31:23]};
      dec.fmt = 2'd2;
      dec.imm = {{16{in_inst[22]}}, in_inst[22:7]};
    end else if (is_ri10) begin
      dec.op  = {3'b0, in_inst[31:24]};
      dec.fmt = 2'd1;
      dec.ra  = REG_W'(in_inst[13:7]);
      dec.imm = {{22{in_inst[23]}}, in_inst[23:14]};
    end else begin
      // Unmatched words still carry RR fields so the consumer can report them.
      dec.op      = in_inst[31:21];
      dec.fmt     = 2'd0;
      dec.ra      = REG_W'(in_inst[13:7]);
      dec.rb      = REG_W'(in_inst[20:14]);
      dec.illegal = !is_rr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_q     <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          out_q     <= dec;
          out_valid <= 1'b1;
          state     <= ONE;
        end
        ONE: begin
          if (accept && drain) begin
            out_q <= dec;
          end else if (accept) begin
            skid_q   <= dec;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: if (drain) begin
          out_q    <= skid_q;
          in_ready <= 1'b1;
          state    <= ONE;
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_op      = out_q.op;
  assign out_fmt     = out_q.fmt;
  assign out_rt      = out_q.rt;
  assign out_ra      = out_q.ra;
  assign out_rb      = out_q.rb;
  assign out_imm     = out_q.imm;
  assign out_illegal = out_q.illegal;

`ifdef SPU_DECODE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_decoded <= '0;
      stat_illegal <= '0;
    end else if (drain) begin
      if (stat_decoded != '1) stat_decoded <= stat_decoded + 32'd1;
      if (out_q.illegal && stat_illegal != '1) stat_illegal <= stat_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spu_inst_decode.sv
// Randomized bench for spu_inst_decode against a queue-based occupancy model and a table-driven reference decoder.
module tb_spu_inst_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [10:0] out_op;
  logic [1:0]  out_fmt;
  logic [6:0]  out_rt, out_ra, out_rb;
  logic [31:0] out_imm;
  logic        out_illegal;
`ifdef SPU_DECODE_STATS_EN
  logic [31:0] stat_decoded, stat_illegal;
  logic [31:0] exp_decoded = '0, exp_illegal = '0;
`endif

  spu_inst_decode #(.INST_W(32), .REG_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_fmt(out_fmt), .out_rt(out_rt), .out_ra(out_ra),
    .out_rb(out_rb), .out_imm(out_imm),
`ifdef SPU_DECODE_STATS_EN
    .stat_decoded(stat_decoded), .stat_illegal(stat_illegal),
`endif
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned op;
    int unsigned fmt;
    int unsigned rt, ra, rb;
    logic [31:0] imm;
    bit          ill;
  } bun_t;

  bun_t q[$];
  int unsigned errors = 0, checks = 0;

  int unsigned ri10_ops[19] = '{'h1C, 'h1D, 'h0C, 'h0D, 'h14, 'h15, 'h16, 'h04, 'h05, 'h06,
                                'h44, 'h45, 'h46, 'h7C, 'h7D, 'h7E, 'h4C, 'h4D, 'h4E};
  int unsigned rr_ops[21] = '{'h0C8, 'h0C0, 'h048, 'h040, 'h340, 'h341, 'h0C2, 'h042, 'h2A5, 'h0C1,
                              'h041, 'h241, 'h0C9, 'h049, 'h249, 'h3C0, 'h3D0, 'h3C8, 'h240, 'h248, 'h250};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext(input int unsigned v, input int unsigned bits);
    int unsigned half = 1 << (bits - 1);
    return (v >= half) ? 32'(v) - 32'(half * 2) : 32'(v);
  endfunction

  function automatic bun_t ref_decode(input logic [31:0] w);
    bun_t b;
    int unsigned u = w;
    bit hit10 = 0, hitrr = 0;
    foreach (ri10_ops[i]) if (u / (1 << 24) == ri10_ops[i]) hit10 = 1;
    foreach (rr_ops[i])   if (u / (1 << 21) == rr_ops[i])   hitrr = 1;
    b = '{op: 0, fmt: 0, rt: u % 128, ra: 0, rb: 0, imm: 0, ill: 0};
    if (u / (1 << 25) == 'h21) begin
      b.op = 'h21; b.fmt = 3; b.imm = 32'((u / 128) % (1 << 18));
    end else if (u / (1 << 23) == 'h081 || u / (1 << 23) == 'h083) begin
      b.op = u / (1 << 23); b.fmt = 2; b.imm = sext((u / 128) % 65536, 16);
    end else if (hit10) begin
      b.op = u / (1 << 24); b.fmt = 1; b.ra = (u / 128) % 128; b.imm = sext((u / (1 << 14)) % 1024, 10);
    end else begin
      b.op = u / (1 << 21); b.ra = (u / 128) % 128; b.rb = (u / (1 << 14)) % 128; b.ill = !hitrr;
    end
    return b;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r = $urandom;
    case ($urandom % 5)
      0: return {7'h21, r[24:0]};
      1: return {($urandom % 2) ? 9'h083 : 9'h081, r[22:0]};
      2: return {8'(ri10_ops[$urandom % 19]), r[23:0]};
      3: return {11'(rr_ops[$urandom % 21]), r[20:0]};
      default: return r;
    endcase
  endfunction

  task automatic compare_all();
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("op", 64'(out_op), 64'(q[0].op));
      chk("fmt", 64'(out_fmt), 64'(q[0].fmt));
      chk("rt", 64'(out_rt), 64'(q[0].rt));
      chk("ra", 64'(out_ra), 64'(q[0].ra));
      chk("rb", 64'(out_rb), 64'(q[0].rb));
      chk("imm", 64'(out_imm), 64'(q[0].imm));
      chk("illegal", 64'(out_illegal), 64'(q[0].ill));
    end
`ifdef SPU_DECODE_STATS_EN
    chk("stat_decoded", 64'(stat_decoded), 64'(exp_decoded));
    chk("stat_illegal", 64'(stat_illegal), 64'(exp_illegal));
`endif
  endtask

  // Called at a falling edge: apply inputs, advance the model, then check at the next falling edge.
  task automatic drive(input bit v, input logic [31:0] w, input bit rdy, input bit fl, output bit taken);
    bit acc, drn;
    in_valid = v; in_inst = w; out_ready = rdy; flush = fl;
    acc = v && (q.size() < 2);
    drn = (q.size() > 0) && rdy;
    if (drn) begin
`ifdef SPU_DECODE_STATS_EN
      if (exp_decoded != '1) exp_decoded++;
      if (q[0].ill && exp_illegal != '1) exp_illegal++;
`endif
      void'(q.pop_front());
    end
    if (acc) q.push_back(ref_decode(w));
    if (fl) q.delete();
    taken = acc && !fl;
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    bit t;
    logic [31:0] words[4];
    int unsigned idx;

    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_op", 64'(out_op), 64'd0);
    chk("rst_imm", 64'(out_imm), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1, {8'h1C, 10'h3FF, 7'd3, 7'd5}, 1, 0, t);
    chk("ai_op", 64'(out_op), 64'h01C);
    chk("ai_fmt", 64'(out_fmt), 64'd1);
    chk("ai_ra", 64'(out_ra), 64'd3);
    chk("ai_rt", 64'(out_rt), 64'd5);
    chk("ai_imm", 64'(out_imm), 64'hFFFFFFFF);
    drive(1, {7'h21, 18'h3FFFF, 7'd9}, 1, 0, t);
    chk("ila_op", 64'(out_op), 64'h021);
    chk("ila_fmt", 64'(out_fmt), 64'd3);
    chk("ila_imm", 64'(out_imm), 64'h0003FFFF);
    chk("ila_ra", 64'(out_ra), 64'd0);
    drive(1, {11'h0C0, 7'd3, 7'd2, 7'd1}, 1, 0, t);
    chk("rr_op", 64'(out_op), 64'h0C0);
    chk("rr_rb", 64'(out_rb), 64'd3);
    chk("rr_ra", 64'(out_ra), 64'd2);
    chk("rr_imm", 64'(out_imm), 64'd0);
    drive(0, '0, 1, 0, t);

    // Back-pressure: four words, consumer stalled for the first three cycles.
    foreach (words[i]) words[i] = rand_inst();
    idx = 0;
    for (int c = 0; c < 20 && (idx < 4 || q.size() > 0); c++) begin
      drive(idx < 4, (idx < 4) ? words[idx] : 32'h0, c >= 3, 0, t);
      if (t) idx++;
      if (c == 2) chk("bp_stall_ready", 64'(in_ready), 64'd0);
    end
    chk("bp_all_out", 64'(idx + 10 * q.size()), 64'd4);

    // Flush while full with a word presented.
    drive(1, rand_inst(), 0, 0, t);
    drive(1, rand_inst(), 0, 0, t);
    drive(1, {8'h1C, 24'h0}, 0, 1, t);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    drive(0, '0, 1, 0, t);
    drive(0, '0, 1, 0, t);

    // Asynchronous reset while stalled full.
    drive(1, rand_inst(), 0, 0, t);
    drive(1, rand_inst(), 0, 0, t);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    chk("arst_op", 64'(out_op), 64'd0);
    chk("arst_imm", 64'(out_imm), 64'd0);
    chk("arst_rt", 64'(out_rt), 64'd0);
    q.delete();
`ifdef SPU_DECODE_STATS_EN
    exp_decoded = '0; exp_illegal = '0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    drive(1, 32'hFFFFFFFF, 1, 0, t);
    chk("ill_flag", 64'(out_illegal), 64'd1);
    chk("ill_op", 64'(out_op), 64'h7FF);
    drive(0, '0, 1, 0, t);
`ifdef SPU_DECODE_STATS_EN
    chk("ill_stat_ill", 64'(stat_illegal), 64'd1);
    chk("ill_stat_dec", 64'(stat_decoded), 64'd1);
`endif

    for (int c = 0; c < 600; c++)
      drive(($urandom % 10) < 7, rand_inst(), ($urandom % 10) < 6, ($urandom % 100) < 3, t);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spu_inst_decode.md
Name: spu_inst_decode

Overview:
- Front-end decoder for the SPU even (simple fixed) pipe.
- Accepts raw 32-bit instruction words over a valid/ready stream and classifies each word into one of four formats: RR, RI10, RI16 or RI18.
- Produces the 11-bit opcode value (the format opcode zero-extended to 11 bits), register fields and an extended immediate.
- Output is registered with a 1-entry skid buffer, so full throughput is sustained under back-pressure. Sits between instruction fetch and issue.

Parameters:
- INST_W, 32, instruction word width; fixed, only 32 is supported.
- REG_W, 7, register-specifier width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards all held instructions.
- in_valid  in  1  instruction word present.
- in_ready  out  1  decoder can accept a word this cycle.
- in_inst  in  32  instruction; bit 31 = SPU bit 0.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  consumer accepts the bundle.
- out_op  out  11  opcode, zero-extended per format.
- out_fmt  out  2  0=RR, 1=RI10, 2=RI16, 3=RI18.
- out_rt  out  7  target register, from in_inst[6:0].
- out_ra  out  7  ra field, from [13:7]; 0 for RI16/RI18.
- out_rb  out  7  rb field, from [20:14]; 0 for non-RR.
- out_imm  out  32  extended immediate; 0 for RR.
- out_illegal  out  1  no supported opcode matched.

Behaviour:
- Classification is combinational on in_inst and checked in this priority order:
  - RI18: [31:25]==7'h21 (ILA). imm = zero-extended [24:7].
  - RI16: [31:23] in {9'h081 ILW, 9'h083 ILH}. imm = sign-extended [22:7].
  - RI10: [31:24] in {1C,1D,0C,0D,14,15,16,04,05,06,44,45,46,7C,7D,7E,4C,4D,4E} (hex). imm = sign-extended [23:14].
  - RR: [31:21] in {0C8,0C0,048,040,340,341,0C2,042,2A5,0C1,041,241,0C9,049,249,3C0,3D0,3C8,240,248,250} (hex).
  - No match: out_illegal=1, out_fmt=RR, out_op=[31:21], other fields decoded as RR, imm=0.
- The opcode sets are disjoint across formats; the priority order only fixes behaviour for the fields.
- Handshake:
  - An input transfer occurs when in_valid && in_ready; an output transfer when out_valid && out_ready.
  - in_ready = !skid_valid, driven directly from a flop.
  - Latency is 1 cycle: a word accepted in cycle N is presented in cycle N+1 if the output register is free or draining.
  - If the output is stalled (out_valid && !out_ready) and a word is accepted, the decoded word goes to the skid register and in_ready drops next cycle.
  - When the output drains and skid is valid, skid moves to the output register and in_ready rises next cycle.
  - Order is strictly preserved.
  - out_* bundle is held stable while out_valid && !out_ready.
- Occupancy states: EMPTY (0 held), ONE (output reg), FULL (output + skid).
  - EMPTY→ONE on accept.
  - ONE→ONE on accept+drain; ONE→FULL on accept w/o drain; ONE→EMPTY on drain w/o accept.
  - FULL→ONE on drain (no accept possible).
- flush:
  - Next cycle: EMPTY, out_valid=0, in_ready=1.
  - A word presented in the flush cycle is dropped.
  - flush has priority over every other event.
- Reset (async assert, sync release by external synchronizer):
  - out_valid=0, in_ready=1, skid empty, all out_* data = 0.
  - Mid-operation reset discards held words with no output transfer.

Optional Feature:
- Macro SPU_DECODE_STATS_EN.
- Defined:
  - Adds outputs stat_decoded[31:0] and stat_illegal[31:0].
  - Counters increment on each output transfer (stat_illegal only when out_illegal=1).
  - Counters saturate at 32'hFFFFFFFF, clear on reset, and are not cleared by flush.
- Undefined: ports and counters are absent; decode behaviour is identical.

Test Plan:
- AI r5,r3,-1: in_inst={8'h1C,10'h3FF,7'd3,7'd5}, out_ready=1 → next cycle out_valid=1, op=11'h01C, fmt=1, ra=3, rt=5, imm=32'hFFFFFFFF.
- ILA r9,0x3FFFF: {7'h21,18'h3FFFF,7'd9} → op=11'h021, fmt=3, imm=32'h0003FFFF, ra=0. RR A r1,r2,r3: {11'h0C0,7'd3,7'd2,7'd1} → op=0C0, rb=3, ra=2, rt=1, imm=0.
- Back-pressure: stream 4 words, out_ready=0 for 3 cycles → at most 2 held, in_ready=0 after the second, outputs stable; release → all 4 emerge in order with no loss or duplication.
- Illegal 32'hFFFFFFFF → out_illegal=1, op=11'h7FF; with SPU_DECODE_STATS_EN, stat_illegal=1 and stat_decoded=1.
- flush while FULL with in_valid=1 → next cycle out_valid=0, in_ready=1, flush-cycle word never appears. Async rst_n low mid-stall → outputs zero immediately.
